// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and LS, LS first with starvation cap.
// Ports: if_* fetch side, ls_* load/store side, mem_* memory side; ARB_PERF_EN adds *_stall_cnt.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_sel,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]         if_stall_cnt,
  output logic [31:0]         ls_stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  logic       owner;
  logic       owner_we;
  logic [3:0] wcnt;
  logic [3:0] starve_cnt;
  logic       ls_win;
  logic       if_win;
  logic       done;

  // rst_n gates the winners so grants drop the moment reset asserts.
  always_comb begin
    ls_win = 1'b0;
    if_win = 1'b0;
    if (rst_n && state == S_IDLE) begin
      ls_win = ls_req && (starve_cnt < SMAX || !if_req);
      if_win = !ls_win && if_req;
    end
    done = (state == S_WAIT) && (wcnt == 4'd1);
  end

  always_comb begin
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_en    = ls_win || if_win;
    mem_sel   = ls_win ? 1'b1 : (if_win ? 1'b0 : owner);
    mem_we    = ls_win && ls_we;
    mem_wstrb = ls_win ? ls_wstrb : '0;
    mem_wdata = ls_win ? ls_wdata : '0;
    mem_addr  = mem_sel ? ls_addr : if_addr;
    if_rvalid = done && !owner;
    ls_rvalid = done && owner;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = (ls_rvalid && !owner_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      owner_we   <= 1'b0;
      wcnt       <= '0;
      starve_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ls_win || if_win) begin
            owner    <= ls_win;
            owner_we <= ls_win && ls_we;
            wcnt     <= LAT;
            state    <= S_WAIT;
          end
          if (if_win || !if_req)
            starve_cnt <= '0;
          else if (ls_win && starve_cnt < SMAX)
            starve_cnt <= starve_cnt + 4'd1;
        end
        S_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt <= '0;
      ls_stall_cnt <= '0;
    end else begin
      if (if_req && !if_gnt && if_stall_cnt != '1)
        if_stall_cnt <= if_stall_cnt + 32'd1;
      if (ls_req && !ls_gnt && ls_stall_cnt != '1)
        ls_stall_cnt <= ls_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queued scoreboard on rvalid.
// Memory model returns preset words one cycle after mem_en.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_sel;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
`ifdef ARB_PERF_EN
  logic [31:0] if_stall_cnt;
  logic [31:0] ls_stall_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    ,
    .if_stall_cnt(if_stall_cnt),
    .ls_stall_cnt(ls_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ls;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   nchk  = 0;
  int   nfail = 0;

  logic [31:0] mem_m [logic [31:0]];

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic push(logic ls, logic [31:0] d);
    exp_t e;
    e.ls   = ls;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // single-cycle latency memory with byte strobes
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        logic [31:0] t;
        t = mem_m.exists(mem_addr) ? mem_m[mem_addr] : '0;
        for (int i = 0; i < 4; i++)
          if (mem_wstrb[i]) t[8*i +: 8] = mem_wdata[8*i +: 8];
        mem_m[mem_addr] = t;
      end else begin
        mem_rdata <= mem_m.exists(mem_addr) ? mem_m[mem_addr] : '0;
      end
    end
  end

  // monitor: pops an expectation whenever an rvalid appears
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (if_rvalid || ls_rvalid) begin
        if (q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL rvalid_unexpected: got if=%b ls=%b expected none",
                   if_rvalid, ls_rvalid);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rv_port", {30'd0, ls_rvalid, if_rvalid},
              e.ls ? 32'd2 : 32'd1);
          chk("rv_data", ls_rvalid ? ls_rdata : if_rdata, e.data);
        end
      end else begin
        chk("rdata_idle_zero", if_rdata | ls_rdata, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    mem_m[32'h100] = 32'hDEADBEEF;
    mem_m[32'h200] = 32'hCAFEF00D;
    mem_m[32'h300] = 32'hAAAAAAAA;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    ls_wdata = '0; ls_wstrb = '0;

    // reset: outputs quiet even with a request pending
    samp();
    chk("rst_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk("rst_mem", {28'd0, mem_en, mem_we, mem_sel, 1'b0}, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_rv", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
    step();
    if_req = 1'b0;
    step();
    rst_n = 1'b1;

    // simultaneous IF/LS: LS first, IF two cycles later
    step();
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_addr = 32'h200;
    samp();
    chk("sim_ls_gnt", {30'd0, ls_gnt, if_gnt}, 32'd2);
    chk("sim_sel0", {31'd0, mem_sel}, 32'd1);
    chk("sim_addr0", mem_addr, 32'h200);
    push(1'b1, 32'hCAFEF00D);
    step();
    ls_req = 1'b0;
    samp();
    chk("sim_wait", {29'd0, mem_en, if_gnt, mem_sel}, 32'd1);
    step();
    samp();
    chk("sim_if_gnt", {30'd0, ls_gnt, if_gnt}, 32'd1);
    chk("sim_sel2", {31'd0, mem_sel}, 32'd0);
    chk("sim_addr2", mem_addr, 32'h100);
    push(1'b0, 32'hDEADBEEF);
    step();
    if_req = 1'b0;
    samp();
`ifdef ARB_PERF_EN
    chk("perf_if_stall", if_stall_cnt, 32'd2);
    chk("perf_ls_stall", ls_stall_cnt, 32'd0);
`endif
    step();
    samp();
    chk("sim_drain", 32'(q.size()), 32'd0);

    // plain IF read
    step();
    if_req = 1'b1; if_addr = 32'h100;
    samp();
    chk("if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("if_mem", {29'd0, mem_en, mem_sel, mem_we}, 32'd4);
    chk("if_addr", mem_addr, 32'h100);
    chk("if_wstrb", {28'd0, mem_wstrb}, 32'd0);
    push(1'b0, 32'hDEADBEEF);
    step();
    if_req = 1'b0;
    samp();
    chk("if_wait_en", {30'd0, mem_en, if_gnt}, 32'd0);
    step();
    samp();
    chk("if_idle", {29'd0, mem_en, if_gnt, ls_gnt}, 32'd0);

    // LS write with partial strobes, then read back
    step();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300;
    ls_wdata = 32'h12345678; ls_wstrb = 4'b0011;
    samp();
    chk("wr_gnt", {30'd0, ls_gnt, mem_sel}, 32'd3);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_wstrb", {28'd0, mem_wstrb}, 32'd3);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    push(1'b1, 32'd0);
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_wstrb = '0;
    samp();
    chk("wr_wait_we", {31'd0, mem_we}, 32'd0);
    step();
    step();
    ls_req = 1'b1; ls_addr = 32'h300;
    samp();
    chk("rd_back_gnt", {31'd0, ls_gnt}, 32'd1);
    push(1'b1, 32'hAAAA5678);
    step();
    ls_req = 1'b0;
    step();

    // starvation: LS at 0,2,4,6 then IF at 8, LS again at 10
    step();
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_addr = 32'h200;
    for (int c = 0; c < 12; c++) begin
      logic el;
      logic ei;
      el = (c == 0 || c == 2 || c == 4 || c == 6 || c == 10);
      ei = (c == 8);
      samp();
      chk($sformatf("stv_c%0d", c), {30'd0, ls_gnt, if_gnt},
          {30'd0, el, ei});
      if (el) push(1'b1, 32'hCAFEF00D);
      if (ei) push(1'b0, 32'hDEADBEEF);
      if (c < 11) begin
        step();
        if (c == 10) begin
          if_req = 1'b0;
          ls_req = 1'b0;
        end
      end
    end
    step();
    samp();
    chk("stv_drain", 32'(q.size()), 32'd0);

    // reset during WAIT abandons the LS read
    step();
    ls_req = 1'b1; ls_addr = 32'h200;
    samp();
    chk("rw_gnt", {31'd0, ls_gnt}, 32'd1);
    step();
    ls_req = 1'b0;
    rst_n = 1'b0;
    samp();
    chk("rw_rv", {30'd0, ls_rvalid, if_rvalid}, 32'd0);
    chk("rw_outs", {29'd0, mem_en, mem_sel, mem_we}, 32'd0);
    chk("rw_rdata", ls_rdata | if_rdata, 32'd0);
`ifdef ARB_PERF_EN
    chk("perf_rst", if_stall_cnt | ls_stall_cnt, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    samp();
    chk("rw_regrant", {31'd0, if_gnt}, 32'd1);
    push(1'b0, 32'hDEADBEEF);
    step();
    if_req = 1'b0;
    step();
    step();
    samp();
    chk("final_drain", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
